// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared widths, FSM states and trap cause codes for the fetch front end.
package fetch_unit_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;
  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_RANGE = 2'd2;
  localparam logic [1:0] CAUSE_ZERO = 2'd3;
endpackage

// File: rtl/fetch_out_reg.sv
// fetch_out_reg: one-entry valid/ready register holding a fetched instruction and its pc.
module fetch_out_reg
  import fetch_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            flush,
  input  logic            ready,
  input  logic [ILEN-1:0] next_instr,
  input  logic [XLEN-1:0] next_pc,
  output logic            valid,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] pc
);
  // load wins over drain so back-to-back transfers sustain one per cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= '0;
      pc <= '0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= next_instr;
      pc <= next_pc;
    end else if (flush || ready) valid <= 1'b0;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: pc register, boot/run/trap FSM and fault detection feeding the output register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int MEM_WORDS = 13
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] pc_o,
  input  logic [ILEN-1:0] instr_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            if_valid_o,
  input  logic            if_ready_i,
  output logic [ILEN-1:0] if_instr_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic            trap_o,
  output logic [1:0]      trap_cause_o
);
  state_t state;
  logic live, misalign, jump, attempt, range_bad, zero_bad, load;
  assign live = state != TRAP;
  assign misalign = live && redirect_valid_i && (redirect_pc_i[1:0] != 2'b00);
  assign jump = live && redirect_valid_i && !misalign;
  assign attempt = state == RUN && !redirect_valid_i && (!if_valid_o || if_ready_i);
  assign range_bad = attempt && ((pc_o >> 2) >= XLEN'(MEM_WORDS));
  assign zero_bad = attempt && !range_bad && instr_i == '0;
  assign load = attempt && !range_bad && !zero_bad;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= BOOT;
      pc_o <= RESET_PC;
      trap_o <= 1'b0;
      trap_cause_o <= CAUSE_NONE;
    end else if (misalign || range_bad || zero_bad) begin
      state <= TRAP;
      trap_o <= 1'b1;
      trap_cause_o <= misalign ? CAUSE_MISALIGN : range_bad ? CAUSE_RANGE : CAUSE_ZERO;
    end else if (jump) begin
      state <= RUN;
      pc_o <= redirect_pc_i;
    end else if (load) pc_o <= pc_o + XLEN'(4);
    else if (state == BOOT) state <= RUN;
  fetch_out_reg u_out (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .flush(jump),
    .ready(if_ready_i),
    .next_instr(instr_i),
    .next_pc(pc_o),
    .valid(if_valid_o),
    .instr(if_instr_o),
    .pc(if_pc_o)
  );
endmodule
